// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: datapath width, bubble instruction and fetch states.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    // ADDI x0,x0,0 -- the canonical bubble, also recognised by decode
    localparam logic [XLEN-1:0] NOP_IW = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_FILL   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SQUASH = 3'd2,
        ST_STALL  = 3'd3,
        ST_HALT   = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: synchronous-read imem, redirect squash, decode stall with
// a one-entry skid buffer, and a terminal halt state.
module rv32i_fetch_unit
    import rv32i_pkg::XLEN, rv32i_pkg::fetch_state_e, rv32i_pkg::ST_FILL, rv32i_pkg::ST_RUN,
           rv32i_pkg::ST_SQUASH, rv32i_pkg::ST_STALL, rv32i_pkg::ST_HALT;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_IW   = rv32i_pkg::NOP_IW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            jump_en_in,
    input  logic [XLEN-1:0] jump_addr_in,
    input  logic            pc_halt_in,
    input  logic            halt_in,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic [XLEN-1:0] imem_rdata_in,
    output logic [XLEN-1:0] iw_out,
    output logic [XLEN-1:0] pc_out,
    output logic            jump_en_out
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [XLEN-1:0] pc_d_q, pc_d_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] iw_q, iw_d;
    logic            jump_en_q, jump_en_d;
    logic [XLEN-1:0] skid_iw_q, skid_iw_d;
    logic            skid_valid_q, skid_valid_d;

    logic [XLEN-1:0] pc_f_inc;
    logic [XLEN-1:0] jump_tgt;

    // Wraps modulo 2^32; targets are forced word aligned.
    assign pc_f_inc = pc_f_q + XLEN'(4);
    assign jump_tgt = jump_addr_in & ~XLEN'(3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FILL;
            pc_f_q       <= RESET_PC;
            pc_d_q       <= RESET_PC;
            pc_out_q     <= RESET_PC;
            iw_q         <= NOP_IW;
            jump_en_q    <= 1'b0;
            skid_iw_q    <= NOP_IW;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            pc_d_q       <= pc_d_d;
            pc_out_q     <= pc_out_d;
            iw_q         <= iw_d;
            jump_en_q    <= jump_en_d;
            skid_iw_q    <= skid_iw_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Next-state logic; priority within a cycle is halt, then redirect, then stall.
    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        pc_d_d       = pc_d_q;
        pc_out_d     = pc_out_q;
        iw_d         = iw_q;
        jump_en_d    = 1'b0;
        skid_iw_d    = skid_iw_q;
        skid_valid_d = skid_valid_q;

        unique case (state_q)
            ST_FILL: begin
                iw_d    = NOP_IW;
                pc_d_d  = pc_f_q;
                pc_f_d  = pc_f_inc;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (halt_in) begin
                    iw_d         = NOP_IW;
                    skid_valid_d = 1'b0;
                    state_d      = ST_HALT;
                end else if (jump_en_in) begin
                    pc_f_d       = jump_tgt;
                    iw_d         = NOP_IW;
                    skid_valid_d = 1'b0;
                    jump_en_d    = 1'b1;
                    state_d      = ST_SQUASH;
                end else if (pc_halt_in) begin
                    // pc_f is held, so the memory keeps returning the next word during the stall
                    skid_iw_d    = imem_rdata_in;
                    skid_valid_d = 1'b1;
                    state_d      = ST_STALL;
                end else begin
                    iw_d     = imem_rdata_in;
                    pc_out_d = pc_d_q;
                    pc_d_d   = pc_f_q;
                    pc_f_d   = pc_f_inc;
                end
            end

            ST_STALL: begin
                if (halt_in) begin
                    iw_d         = NOP_IW;
                    skid_valid_d = 1'b0;
                    state_d      = ST_HALT;
                end else if (jump_en_in) begin
                    pc_f_d       = jump_tgt;
                    iw_d         = NOP_IW;
                    skid_valid_d = 1'b0;
                    jump_en_d    = 1'b1;
                    state_d      = ST_SQUASH;
                end else if (!pc_halt_in) begin
                    iw_d         = skid_valid_q ? skid_iw_q : imem_rdata_in;
                    pc_out_d     = pc_d_q;
                    skid_valid_d = 1'b0;
                    pc_d_d       = pc_f_q;
                    pc_f_d       = pc_f_inc;
                    state_d      = ST_RUN;
                end
            end

            ST_SQUASH: begin
                if (halt_in) begin
                    iw_d    = NOP_IW;
                    state_d = ST_HALT;
                end else begin
                    // Word on imem_rdata_in is from the old path; the target read starts now.
                    iw_d    = NOP_IW;
                    pc_d_d  = pc_f_q;
                    pc_f_d  = pc_f_inc;
                    state_d = ST_RUN;
                end
            end

            ST_HALT: begin
                iw_d = NOP_IW;
            end

            default: begin
                iw_d         = NOP_IW;
                skid_valid_d = 1'b0;
                state_d      = ST_FILL;
            end
        endcase
    end

    assign imem_addr_out = pc_f_q;
    assign iw_out        = iw_q;
    assign pc_out        = pc_out_q;
    assign jump_en_out   = jump_en_q;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit: two instances (RESET_PC 0 and FFFF_FFF8) share stimulus
// and are compared every cycle against an instruction-stream model.
module tb_rv32i_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jump_en_in = 1'b0;
    logic [31:0] jump_addr_in = 32'h0;
    logic        pc_halt_in = 1'b0;
    logic        halt_in = 1'b0;

    logic [31:0] addr0, rdata0, iw0, pco0;
    logic [31:0] addr1, rdata1, iw1, pco1;
    logic        jeo0, jeo1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32i_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_IW(NOP)) dut0 (
        .clk(clk), .reset(reset), .jump_en_in(jump_en_in), .jump_addr_in(jump_addr_in),
        .pc_halt_in(pc_halt_in), .halt_in(halt_in), .imem_addr_out(addr0),
        .imem_rdata_in(rdata0), .iw_out(iw0), .pc_out(pco0), .jump_en_out(jeo0)
    );

    rv32i_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .NOP_IW(NOP)) dut1 (
        .clk(clk), .reset(reset), .jump_en_in(jump_en_in), .jump_addr_in(jump_addr_in),
        .pc_halt_in(pc_halt_in), .halt_in(halt_in), .imem_addr_out(addr1),
        .imem_rdata_in(rdata1), .iw_out(iw1), .pc_out(pco1), .jump_en_out(jeo1)
    );

    // Memory contents: word i (byte address 4*i) holds 32'h1000_0000 + i.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        rdata0 <= memf(addr0);
        rdata1 <= memf(addr1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: next instruction to deliver, pending bubbles, fill/halt flags.
    logic [31:0] rpc [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
    logic [31:0] m_next [2], m_pc [2], m_iw [2], m_addr [2];
    int          m_bub [2];
    bit          m_fill [2], m_halt [2], m_jeo [2];
    bit          armed = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_next[k] = rpc[k];
                m_pc[k]   = rpc[k];
                m_iw[k]   = NOP;
                m_jeo[k]  = 1'b0;
                m_bub[k]  = 1;
                m_fill[k] = 1'b1;
                m_halt[k] = 1'b0;
                armed     = 1'b1;
            end else if (m_halt[k]) begin
                m_jeo[k] = 1'b0;
            end else if (halt_in && !m_fill[k]) begin
                m_halt[k] = 1'b1;
                m_iw[k]   = NOP;
                m_jeo[k]  = 1'b0;
            end else if (jump_en_in && m_bub[k] == 0) begin
                m_next[k] = {jump_addr_in[31:2], 2'b00};
                m_iw[k]   = NOP;
                m_jeo[k]  = 1'b1;
                m_bub[k]  = 1;
            end else if (m_bub[k] > 0) begin
                m_iw[k]   = NOP;
                m_bub[k]  = m_bub[k] - 1;
                m_fill[k] = 1'b0;
                m_jeo[k]  = 1'b0;
            end else if (pc_halt_in) begin
                m_jeo[k] = 1'b0;
            end else begin
                m_iw[k]   = memf(m_next[k]);
                m_pc[k]   = m_next[k];
                m_next[k] = m_next[k] + 32'd4;
                m_jeo[k]  = 1'b0;
            end
            if (!m_halt[k])
                m_addr[k] = (m_bub[k] > 0) ? m_next[k] : m_next[k] + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("iw0",   iw0,   m_iw[0]);
            check("pc0",   pco0,  m_pc[0]);
            check("jeo0",  32'(jeo0), 32'(m_jeo[0]));
            check("addr0", addr0, m_addr[0]);
            check("iw1",   iw1,   m_iw[1]);
            check("pc1",   pco1,  m_pc[1]);
            check("jeo1",  32'(jeo1), 32'(m_jeo[1]));
            check("addr1", addr1, m_addr[1]);
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset, with halt_in raised during FILL (must be ignored)
        step(2);
        check("lit_rst_iw", iw0, NOP);
        check("lit_rst_pc1", pco1, 32'hFFFF_FFF8);
        reset = 1'b0;
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        check("lit_fill_iw", iw0, NOP);
        check("lit_fill_addr1", addr1, 32'hFFFF_FFFC);
        step();
        check("lit_w0_iw", iw0, 32'h1000_0000);
        check("lit_w0_pc", pco0, 32'h0);
        check("lit_wrap_pc1a", pco1, 32'hFFFF_FFF8);
        step();
        check("lit_w1_pc", pco0, 32'h4);
        check("lit_wrap_pc1b", pco1, 32'hFFFF_FFFC);
        step();
        check("lit_w2_pc", pco0, 32'h8);
        check("lit_wrap_pc1c", pco1, 32'h0);
        check("lit_wrap_iw1c", iw1, 32'h1000_0000);

        // Redirect to 0x40 at pc_out=8; second cycle of jump_en_in falls in SQUASH
        jump_en_in = 1'b1; jump_addr_in = 32'h40;
        step();
        check("lit_jeo", 32'(jeo0), 32'd1);
        check("lit_j_nop1", iw0, NOP);
        jump_addr_in = 32'h200;
        step();
        jump_en_in = 1'b0;
        check("lit_j_nop2", iw0, NOP);
        check("lit_jeo_off", 32'(jeo0), 32'd0);
        step();
        check("lit_j_iw", iw0, 32'h1000_0010);
        check("lit_j_pc", pco0, 32'h40);
        step();

        // Stall three cycles at pc_out=0x10
        jump_en_in = 1'b1; jump_addr_in = 32'h10;
        step();
        jump_en_in = 1'b0;
        step(2);
        check("lit_s_pc0", pco0, 32'h10);
        pc_halt_in = 1'b1;
        step(3);
        check("lit_s_hold_pc", pco0, 32'h10);
        check("lit_s_hold_iw", iw0, 32'h1000_0004);
        pc_halt_in = 1'b0;
        step();
        check("lit_s_rel1", pco0, 32'h14);
        check("lit_s_rel1_iw", iw0, 32'h1000_0005);
        step();
        check("lit_s_rel2", pco0, 32'h18);

        // Redirect and stall together; stall also held through SQUASH
        jump_en_in = 1'b1; pc_halt_in = 1'b1; jump_addr_in = 32'h80;
        step();
        jump_en_in = 1'b0;
        step();
        pc_halt_in = 1'b0;
        step();
        check("lit_js_pc", pco0, 32'h80);
        check("lit_js_iw", iw0, 32'h1000_0020);

        // Redirect out of STALL to an unaligned target
        pc_halt_in = 1'b1;
        step();
        jump_en_in = 1'b1; jump_addr_in = 32'h43;
        step();
        jump_en_in = 1'b0; pc_halt_in = 1'b0;
        step(2);
        check("lit_ua_pc0", pco0, 32'h40);
        check("lit_ua_pc1", pco1, 32'h40);
        step(2);

        // Halt at pc_out=0x20, then inputs ignored
        jump_en_in = 1'b1; jump_addr_in = 32'h20;
        step();
        jump_en_in = 1'b0;
        step(2);
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        check("lit_h_iw", iw0, NOP);
        check("lit_h_addr", addr0, 32'h28);
        jump_en_in = 1'b1; jump_addr_in = 32'h300; pc_halt_in = 1'b1;
        step(3);
        jump_en_in = 1'b0; pc_halt_in = 1'b0;
        check("lit_h_addr2", addr0, 32'h28);
        check("lit_h_pc", pco0, 32'h20);
        step(2);

        // Reset from HALT
        reset = 1'b1;
        step();
        check("lit_rh_addr", addr0, 32'h0);
        reset = 1'b0;
        step(2);
        check("lit_rh_iw", iw0, 32'h1000_0000);
        step(3);

        // Reset mid-stall
        pc_halt_in = 1'b1;
        step(2);
        reset = 1'b1;
        step();
        reset = 1'b0; pc_halt_in = 1'b0;
        step(2);
        check("lit_rs_pc", pco0, 32'h0);
        step(2);

        // Reset mid-squash
        jump_en_in = 1'b1; jump_addr_in = 32'h40;
        step();
        jump_en_in = 1'b0; reset = 1'b1;
        step();
        check("lit_rq_jeo", 32'(jeo0), 32'd0);
        reset = 1'b0;
        step(2);
        check("lit_rq_iw", iw0, 32'h1000_0000);
        step(3);

        // Halt during SQUASH freezes the redirect target address
        jump_en_in = 1'b1; jump_addr_in = 32'h60;
        step();
        jump_en_in = 1'b0; halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        step(2);
        check("lit_hq_addr", addr0, 32'h60);
        check("lit_hq_iw", iw0, NOP);

        // Halt while stalled, then final restart
        reset = 1'b1;
        step();
        reset = 1'b0;
        step(4);
        pc_halt_in = 1'b1;
        step();
        halt_in = 1'b1;
        step();
        halt_in = 1'b0; pc_halt_in = 1'b0;
        step(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_fetch_unit.md
RV32I_FETCH_UNIT -- requirements
Module: rv32i_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_IW, 32'h0000_0013, instruction word injected on bubbles (ADDI x0,x0,0).
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 jump_en_in  input  1  redirect request from decode stage.
REQ-006 jump_addr_in  input  32  redirect target, valid while jump_en_in=1.
REQ-007 pc_halt_in  input  1  stall request from decode stage (load/store hazard).
REQ-008 halt_in  input  1  EBREAK/ECALL seen in decode; freezes fetch.
REQ-009 imem_addr_out  output  32  instruction memory byte address, equals fetch PC register pc_f.
REQ-010 imem_rdata_in  input  32  instruction memory data, synchronous read, valid one cycle after address.
REQ-011 iw_out  output  32  registered instruction word to decode stage.
REQ-012 pc_out  output  32  registered PC of iw_out.
REQ-013 jump_en_out  output  1  registered one-cycle pulse marking the first cycle after an accepted redirect.

Function
REQ-014 Internal registers: pc_f (address being fetched), pc_d (address whose data is on imem_rdata_in), skid_iw/skid_valid (one-entry hold buffer), state.
REQ-015 States: FILL, RUN, SQUASH, STALL, HALT; reset enters FILL.
REQ-016 FILL: one cycle, iw_out<=NOP_IW, pc_d<=pc_f, pc_f<=pc_f+4, next RUN.
REQ-017 RUN, no events: iw_out<=imem_rdata_in, pc_out<=pc_d, pc_d<=pc_f, pc_f<=pc_f+4.
REQ-018 Latency: first real instruction (address RESET_PC) appears on iw_out two edges after reset deasserts.
REQ-019 PC arithmetic is modulo 2^32; pc_f=32'hFFFF_FFFC advances to 32'h0.
REQ-020 Accepted redirect (jump_en_in=1 in RUN or STALL): pc_f<={jump_addr_in[31:2],2'b00}, iw_out<=NOP_IW, skid_valid<=0, jump_en_out<=1, next SQUASH.
REQ-021 SQUASH: in-flight wrong-path word discarded, iw_out<=NOP_IW, pc_d<=pc_f, pc_f<=pc_f+4, jump_en_out<=0, next RUN; exactly two NOP bubbles follow every redirect.
REQ-022 jump_en_in during FILL or SQUASH: ignored (decode stage suppresses re-issue while jump_en_out asserted).
REQ-023 Stall entry (pc_halt_in=1 in RUN): iw_out, pc_out, pc_f, pc_d hold; skid_iw<=imem_rdata_in, skid_valid<=1; next STALL.
REQ-024 STALL while pc_halt_in=1: all registers hold; imem_addr_out stays at pc_f.
REQ-025 Stall release: iw_out<=skid_iw, pc_out<=pc_d, skid_valid<=0, pc_d<=pc_f, pc_f<=pc_f+4, next RUN; no instruction lost or duplicated.
REQ-026 Priority per cycle: reset > halt_in > jump_en_in > pc_halt_in.
REQ-027 halt_in=1 in any state except FILL: next HALT, iw_out<=NOP_IW.
REQ-028 HALT: pc_f, pc_d, pc_out frozen, iw_out=NOP_IW, jump_en_out=0, all inputs ignored until reset.
REQ-029 jump_en_out is 0 in every cycle except the one following an accepted redirect.

Reset
REQ-030 On reset: pc_f=RESET_PC, pc_d=RESET_PC, pc_out=RESET_PC, iw_out=NOP_IW, jump_en_out=0, skid_valid=0, state=FILL.
REQ-031 Reset asserted mid-stall, mid-squash or in HALT discards all pending state with no residual bubble or redirect.

Structure
REQ-032 Shared package rv32i_pkg holds NOP_IW, the state enum type, and the XLEN=32 constant; the decode stage imports the same NOP_IW.
REQ-033 Single module, no sub-modules; the skid buffer stays inline.

Verification
REQ-034 Reset release, memory word i = 32'h1000_0000+i: iw_out shows NOP, NOP, then word 0 with pc_out=0, word 1 with pc_out=4, one per cycle.
REQ-035 jump_en_in pulse, jump_addr_in=32'h40, while pc_out=8: jump_en_out=1 next cycle, two NOPs, then word at 0x40 with pc_out=0x40.
REQ-036 pc_halt_in high 3 cycles while pc_out=0x10: iw_out/pc_out hold 0x10 for 3 cycles, then 0x14, 0x18 with no gap or repeat.
REQ-037 jump_en_in and pc_halt_in asserted together, target 0x80: redirect taken, skid cleared, next real word from 0x80.
REQ-038 halt_in pulse at pc_out=0x20: iw_out=NOP_IW indefinitely, imem_addr_out frozen, later jump_en_in ignored; reset restarts at RESET_PC.
REQ-039 RESET_PC=32'hFFFF_FFF8: pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; jump_addr_in=32'h43 is fetched as 0x40.
